// File: rtl/puf_race_sequencer_if.sv
// Request/response handshake and race-cell wiring for puf_race_sequencer.
// master: key-derivation logic together with the race cell; slave: the sequencer.
interface puf_race_sequencer_if #(
    parameter int CHAL_W    = 8,
    parameter int RESP_BITS = 32
);
    logic                 start;
    logic [CHAL_W-1:0]    challenge;
    logic                 busy;
    logic [CHAL_W-1:0]    chal_out;
    logic                 launch;
    logic                 arr_a;
    logic                 arr_b;
    logic                 race_bit;
    logic [RESP_BITS-1:0] response;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 timeout_err;

    modport master (
        output start, challenge, resp_ready, arr_a, arr_b, race_bit,
        input  busy, chal_out, launch, response, resp_valid, timeout_err
    );

    modport slave (
        input  start, challenge, resp_ready, arr_a, arr_b, race_bit,
        output busy, chal_out, launch, response, resp_valid, timeout_err
    );
endinterface

// File: rtl/puf_race_sequencer.sv
// Runs RESP_BITS arbiter-PUF races on consecutive challenges and assembles the
// winner bits into one response word offered on a valid/ready handshake.
module puf_race_sequencer #(
    parameter int RESP_BITS      = 32,
    parameter int CHAL_W         = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    puf_race_sequencer_if.slave bus
);
    localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(RESP_BITS - 1);
    localparam logic [SET_W-1:0]  SETTLE_DONE = SET_W'(SETTLE_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FIRE,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t               r_state;
    logic [CHAL_W-1:0]    r_base;
    logic [CHAL_W-1:0]    r_chal_out;
    logic [IDX_W-1:0]     r_idx;
    logic [SET_W-1:0]     r_settle;
    logic [WAIT_W-1:0]    r_wait;
    logic [RESP_BITS-1:0] r_response;
    logic                 r_busy;
    logic                 r_launch;
    logic                 r_resp_valid;
    logic                 r_timeout_err;
    logic                 r_fire_to;

    logic                 w_quiet;
    logic                 w_both;
    logic [SET_W-1:0]     w_settle_next;
    logic [IDX_W-1:0]     w_idx_next;

    assign w_quiet       = ~bus.arr_a & ~bus.arr_b;
    assign w_both        = bus.arr_a & bus.arr_b;
    assign w_settle_next = w_quiet ? (r_settle + SET_W'(1)) : '0;
    assign w_idx_next    = r_idx + IDX_W'(1);

    // r_wait counts cycles spent in the current SETUP or FIRE visit; it is
    // cleared on every entry so each phase gets its own timeout window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_chal_out    <= '0;
            r_idx         <= '0;
            r_settle      <= '0;
            r_wait        <= '0;
            r_response    <= '0;
            r_busy        <= 1'b0;
            r_launch      <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_fire_to     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base        <= bus.challenge;
                        r_chal_out    <= bus.challenge;
                        r_idx         <= '0;
                        r_settle      <= '0;
                        r_wait        <= '0;
                        r_response    <= '0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_settle_next == SETTLE_DONE) begin
                        r_launch <= 1'b1;
                        r_wait   <= '0;
                        r_state  <= S_FIRE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_launch      <= 1'b1;
                        r_wait        <= '0;
                        r_state       <= S_FIRE;
                    end else begin
                        r_settle <= w_settle_next;
                        r_wait   <= r_wait + WAIT_W'(1);
                    end
                end

                S_FIRE: begin
                    if (w_both) begin
                        r_fire_to <= 1'b0;
                        r_launch  <= 1'b0;
                        r_state   <= S_CAPTURE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_fire_to     <= 1'b1;
                        r_launch      <= 1'b0;
                        r_state       <= S_CAPTURE;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end

                S_CAPTURE: begin
                    // A race that never completed reports A-first rather than
                    // whatever the cell output happens to show.
                    r_response[r_idx] <= r_fire_to ? 1'b0 : bus.race_bit;
                    if (r_idx == IDX_LAST) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_idx      <= w_idx_next;
                        r_chal_out <= r_base + CHAL_W'(w_idx_next);
                        r_settle   <= '0;
                        r_wait     <= '0;
                        r_state    <= S_SETUP;
                    end
                end

                S_HOLD: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_launch     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.chal_out    = r_chal_out;
    assign bus.launch      = r_launch;
    assign bus.response    = r_response;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_puf_race_sequencer.sv
// Bench for puf_race_sequencer: behavioural race cell, table of response words,
// and hand-written sequences for arrival glitches, held responses and reset.
module tb_puf_race_sequencer;
    localparam int RESP_BITS = 4;
    localparam int CHAL_W    = 8;
    localparam int SETTLE    = 4;
    localparam int TIMEOUT   = 64;

    typedef struct {
        logic [7:0] base;
        logic [3:0] bits;
        int         delay;
        int         block;
        logic [3:0] exp_resp;
        logic       exp_terr;
    } row_t;

    typedef struct {
        logic [7:0] chal;
        int         gap;
    } launch_exp_t;

    typedef struct {
        logic [3:0] resp;
        logic       terr;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    puf_race_sequencer_if #(.CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS)) bus ();

    puf_race_sequencer #(
        .RESP_BITS     (RESP_BITS),
        .CHAL_W        (CHAL_W),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    row_t        rows[6];
    launch_exp_t chal_q[$];
    resp_exp_t   resp_q[$];

    // Race-cell model state
    logic [3:0] cfg_bits  = 4'b0000;
    int         cfg_delay = 1;
    int         cfg_block = -1;
    int         m_race    = 0;
    int         m_lcnt    = 0;
    logic       m_prev_l  = 1'b0;
    logic       m_a       = 1'b0;
    logic       m_b       = 1'b0;
    logic       m_bit     = 1'b0;
    logic       m_stuck_a = 1'b0;

    assign bus.arr_a    = m_a | m_stuck_a;
    assign bus.arr_b    = m_b;
    assign bus.race_bit = m_bit;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Both arrivals rise on FIRE cycle (delay-1); the blocked race never sees B.
    always @(negedge clk) begin
        if (bus.launch) begin
            m_lcnt++;
            m_bit = cfg_bits[m_race];
            if (m_lcnt >= cfg_delay) begin
                m_a = 1'b1;
                m_b = (m_race != cfg_block);
            end
            m_prev_l = 1'b1;
        end else begin
            if (m_prev_l) m_race++;
            m_prev_l = 1'b0;
            m_lcnt   = 0;
            m_a      = 1'b0;
            m_b      = 1'b0;
        end
    end

    int          mon_cyc       = 0;
    int          mon_last_rise = 0;
    logic        mon_prev_l    = 1'b0;
    launch_exp_t mon_le;
    resp_exp_t   mon_re;

    always @(negedge clk) begin
        #1;
        mon_cyc++;
        if (bus.launch && !mon_prev_l) begin
            check("launch_expected", 64'(chal_q.size() > 0), 64'd1);
            if (chal_q.size() > 0) begin
                mon_le = chal_q.pop_front();
                check("chal_out", 64'(bus.chal_out), 64'(mon_le.chal));
                if (mon_le.gap != 0)
                    check("bit_period", 64'(mon_cyc - mon_last_rise), 64'(mon_le.gap));
            end
            mon_last_rise = mon_cyc;
        end
        mon_prev_l = bus.launch;
        if (bus.resp_valid && bus.resp_ready) begin
            check("resp_expected", 64'(resp_q.size() > 0), 64'd1);
            if (resp_q.size() > 0) begin
                mon_re = resp_q.pop_front();
                check("response", 64'(bus.response), 64'(mon_re.resp));
                check("timeout_err", 64'(bus.timeout_err), 64'(mon_re.terr));
            end
        end
    end

    function automatic int fire_len(input int r, input int race);
        return (race == rows[r].block) ? TIMEOUT : rows[r].delay;
    endfunction

    task automatic prep_row(input int r);
        launch_exp_t le;
        resp_exp_t   re;
        cfg_bits  = rows[r].bits;
        cfg_delay = rows[r].delay;
        cfg_block = rows[r].block;
        m_race    = 0;
        for (int i = 0; i < RESP_BITS; i++) begin
            le.chal = rows[r].base + 8'(i);
            le.gap  = (i == 0) ? 0 : SETTLE + fire_len(r, i - 1) + 1;
            chal_q.push_back(le);
        end
        re.resp = rows[r].exp_resp;
        re.terr = rows[r].exp_terr;
        resp_q.push_back(re);
    endtask

    task automatic start_word(input logic [7:0] base);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.challenge = base;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.challenge = ~base;
        check("start_busy", 64'(bus.busy), 64'd1);
        check("start_clr_terr", 64'(bus.timeout_err), 64'd0);
        check("start_clr_resp", 64'(bus.response), 64'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("word_done", 64'(bus.busy), 64'd0);
        check("scoreboard_drained", 64'(chal_q.size() + resp_q.size()), 64'd0);
    endtask

    task automatic run_row(input int r);
        prep_row(r);
        start_word(rows[r].base);
        wait_idle(600);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   launches;
        int   bad;
        logic [3:0] snap;

        rows[0] = '{8'h10, 4'b1101, 4, -1, 4'b1101, 1'b0};
        rows[1] = '{8'hFE, 4'b0110, 1, -1, 4'b0110, 1'b0};
        rows[2] = '{8'h80, 4'b1111, 2,  2, 4'b1011, 1'b1};
        rows[3] = '{8'h00, 4'b1010, 3, -1, 4'b1010, 1'b0};
        rows[4] = '{8'h40, 4'b0101, 1, -1, 4'b0101, 1'b0};
        rows[5] = '{8'h20, 4'b1001, 2, -1, 4'b1001, 1'b0};

        bus.start      = 1'b0;
        bus.challenge  = 8'h00;
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_launch", 64'(bus.launch), 64'd0);
        check("rst_chal_out", 64'(bus.chal_out), 64'd0);
        check("rst_response", 64'(bus.response), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            run_row(r);
            if (r == 2) begin
                repeat (3) @(negedge clk);
                check("terr_sticky_idle", 64'(bus.timeout_err), 64'd1);
            end
        end

        // Arrival A stuck high for the first 10 SETUP cycles.
        prep_row(4);
        m_stuck_a = 1'b1;
        start_word(rows[4].base);
        launches = 0;
        for (int i = 0; i < 10; i++) begin
            launches += int'(bus.launch);
            @(negedge clk);
        end
        check("stuck_no_launch", 64'(launches), 64'd0);
        m_stuck_a = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.launch) break;
        end
        check("settle_after_drop", 64'(n), 64'(SETTLE));
        wait_idle(600);

        // Response held while the consumer stalls and start pulses.
        prep_row(5);
        bus.resp_ready = 1'b0;
        start_word(rows[5].base);
        n = 0;
        while (!bus.resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", 64'(bus.resp_valid), 64'd1);
        snap = bus.response;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start     = 1'(i % 2);
            bus.challenge = 8'hA5;
            if (bus.response !== snap || bus.resp_valid !== 1'b1 || bus.busy !== 1'b1) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", 64'(bus.resp_valid), 64'd0);
        check("hold_release_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        check("start_ignored_hold", 64'(bus.busy), 64'd0);
        check("scoreboard_drained", 64'(chal_q.size() + resp_q.size()), 64'd0);

        // Reset during FIRE of race 1, then a clean word.
        prep_row(0);
        start_word(rows[0].base);
        n = 0;
        while (!(m_race == 1 && bus.launch) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_in_fire1", 64'(bus.launch && m_race == 1), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_launch", 64'(bus.launch), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("abort_response", 64'(bus.response), 64'd0);
        check("abort_chal_out", 64'(bus.chal_out), 64'd0);
        rst = 1'b0;
        chal_q.delete();
        resp_q.delete();
        repeat (2) @(negedge clk);
        run_row(0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/puf_race_sequencer.md
Name: puf_race_sequencer

Overview:
- Drives one race-arbiter PUF cell: applies a challenge, launches the two delay paths, waits for both arrivals and captures the race winner bit.
- Repeats this for RESP_BITS consecutive challenges (base + index) and presents the assembled response word on a valid/ready handshake.
- Sits between the PUF key-derivation logic and the race cell / delay-path array.

Parameters:
- RESP_BITS, 32, number of race bits per response word (>=1).
- CHAL_W, 8, challenge width driven to the delay-path selectors.
- SETTLE_CYCLES, 4, cycles launch stays low with both arrivals low before each launch (>=1).
- TIMEOUT_CYCLES, 64, maximum cycles waited in SETUP or FIRE (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a response; accepted only in IDLE
- challenge  in  CHAL_W  base challenge; sampled on accepted start
- busy  out  1  high in every state except IDLE
- chal_out  out  CHAL_W  challenge to the delay paths
- launch  out  1  rising edge fires both delay paths
- arr_a  in  1  path A arrival, synchronous to clk
- arr_b  in  1  path B arrival, synchronous to clk
- race_bit  in  1  race cell output (1 = B first, 0 = A first)
- response  out  RESP_BITS  assembled response; bit i = race i
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- timeout_err  out  1  sticky; at least one race of the current word timed out

Behaviour:
- Reset values: busy=0, launch=0, chal_out=0, response=0, resp_valid=0, timeout_err=0, idx=0, state IDLE. Reset mid-operation aborts the word; launch is low from the next edge and no partial response is presented.
- States: IDLE, SETUP, FIRE, CAPTURE, HOLD.
- IDLE -> SETUP on start.
  - base := challenge, idx := 0, response := 0, timeout_err := 0.
  - start in any other state is ignored.
- SETUP:
  - launch=0, chal_out = base + idx (mod 2^CHAL_W).
  - settle counter increments each cycle arr_a=0 and arr_b=0; it clears to 0 on any cycle either arrival is high.
  - -> FIRE when the counter reaches SETTLE_CYCLES.
  - If TIMEOUT_CYCLES cycles elapse in SETUP first: set timeout_err, -> FIRE anyway.
- FIRE:
  - launch=1; the wait counter starts at 0 on entry.
  - -> CAPTURE on the first cycle with arr_a=1 and arr_b=1 (one arrival alone does not advance).
  - If the wait counter reaches TIMEOUT_CYCLES first: set timeout_err, force the captured bit to 0, -> CAPTURE.
- CAPTURE (1 cycle):
  - launch=0; response[idx] := race_bit, or 0 on FIRE timeout.
  - If idx = RESP_BITS-1 -> HOLD; else idx := idx+1 and -> SETUP.
- HOLD:
  - resp_valid=1; response and timeout_err stable.
  - On resp_valid && resp_ready: resp_valid=0 on the next edge, -> IDLE.
  - start is ignored in HOLD.
- Per-bit latency with immediate arrivals is SETTLE_CYCLES + 1 (FIRE) + 1 (CAPTURE) cycles. A start is never accepted on the same edge a response is consumed.
- chal_out wraps modulo 2^CHAL_W; for example base 0xFE with 4 bits gives 0xFE, 0xFF, 0x00, 0x01.
- timeout_err holds until the next accepted start.

Test Plan:
1. RESP_BITS=4, SETTLE=4, base 0x10. The model raises both arrivals 3 cycles after launch and returns race_bit 1,0,1,1 -> chal_out 0x10..0x13, response=4'b1101, resp_valid high until resp_ready, no timeout_err, 9 cycles per bit.
2. Base 0xFE, 4 bits -> chal_out sequence 0xFE, 0xFF, 0x00, 0x01.
3. arr_b never rises on race 2, TIMEOUT=64 -> FIRE lasts 64 cycles, response[2]=0, timeout_err=1 in HOLD; the next start clears timeout_err.
4. arr_a stuck high entering SETUP for 10 cycles -> launch held low, settle counter restarts; launch occurs SETTLE_CYCLES cycles after arr_a drops.
5. resp_ready low for 20 cycles in HOLD while start pulses -> response stable, start ignored, IDLE only after the handshake.
6. rst asserted during FIRE of race 1 -> next cycle launch=0, busy=0, resp_valid=0, response=0; a new start then runs the full sequence correctly.
